mult4_share_ctrl: RTL and testbench

Sequencing and arbitration controller that shares one combinational 4x4 array multiplier (8-bit product, built from half/full adders) between two requesters. It grants one requester at a time, round-robin. It registers the granted operands onto the multiplier inputs and holds them stable for a programmable settle window so the gate-delay ripple completes. It then captures the product and returns it to the winner with a one-cycle done pulse. It sits between the requesting datapaths and the shared multiplier instance, which lives outside this block.

---
 rtl/mult4_share_ctrl_pkg.sv | 17 +
 rtl/mult4_share_ctrl_rr_pick2.sv | 14 +
 rtl/mult4_share_ctrl.sv | 137 +++++++++++++
 tb/tb_mult4_share_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mult4_share_ctrl_pkg.sv
// Shared definitions for the shared 4x4 multiplier controller: FSM encoding,
// datapath widths and the legal settle-window range.
package mult4_share_ctrl_pkg;

    localparam int unsigned OP_W       = 4;
    localparam int unsigned PROD_W     = 8;
    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mult4_share_ctrl_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins, and on a tie
// the requester that was not granted last time wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic winner
);

    assign gnt_valid = req0 | req1;
    assign winner    = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mult4_share_ctrl.sv
// Arbitrates two requesters onto one external 4x4 multiplier, holds its inputs
// for SETTLE_CYCLES, then captures the product and pulses the winner's done.
module mult4_share_ctrl
    import mult4_share_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   a0,
    input  logic [OP_W-1:0]   b0,
    input  logic [OP_W-1:0]   a1,
    input  logic [OP_W-1:0]   b1,
    output logic              done0,
    output logic              done1,
    output logic [PROD_W-1:0] prod0,
    output logic [PROD_W-1:0] prod1,
    output logic              busy,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_z
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               winner_q, winner_d;
    logic [OP_W-1:0]    mul_a_q, mul_a_d;
    logic [OP_W-1:0]    mul_b_q, mul_b_d;
    logic [PROD_W-1:0]  prod0_q, prod0_d;
    logic [PROD_W-1:0]  prod1_q, prod1_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic               busy_q, busy_d;
    logic               gnt_valid_s;
    logic               pick_s;

    rr_pick2 u_pick (
        .req0      (req0),
        .req1      (req1),
        .last      (last_q),
        .gnt_valid (gnt_valid_s),
        .winner    (pick_s)
    );

    // Next-state and output computation; done and busy are precomputed so they
    // leave the block straight from flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        winner_d = winner_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        prod0_d  = prod0_q;
        prod1_d  = prod1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    mul_a_d  = pick_s ? a1 : a0;
                    mul_b_d  = pick_s ? b1 : b0;
                    cnt_d    = CNT_LOAD;
                    last_d   = pick_s;
                    winner_d = pick_s;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    if (winner_q) begin
                        prod1_d = mul_z;
                        done1_d = 1'b1;
                    end else begin
                        prod0_d = mul_z;
                        done0_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State register with synchronous reset; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            last_q   <= 1'b1;
            winner_q <= 1'b0;
            mul_a_q  <= {OP_W{1'b0}};
            mul_b_q  <= {OP_W{1'b0}};
            prod0_q  <= {PROD_W{1'b0}};
            prod1_q  <= {PROD_W{1'b0}};
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            prod0_q  <= prod0_d;
            prod1_q  <= prod1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
        end
    end

    assign done0 = done0_q;
    assign done1 = done1_q;
    assign prod0 = prod0_q;
    assign prod1 = prod1_q;
    assign busy  = busy_q;
    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;

endmodule

// File: tb/tb_mult4_share_ctrl.sv
// Bench for mult4_share_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mult4_share_ctrl;

    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       rst, req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       done0, done1, busy;
    logic [7:0] prod0, prod1, mul_z;
    logic [3:0] mul_a, mul_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // The shared multiplier lives outside the controller.
    assign mul_z = {4'b0000, mul_a} * {4'b0000, mul_b};

    mult4_share_ctrl #(.SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .prod0(prod0), .prod1(prod1),
        .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z)
    );

    // Transaction model: an operation granted in cycle t completes with done in
    // cycle t+SC+1, followed by one idle cycle in which requests are ignored.
    bit         m_valid = 1'b0;
    bit         m_active, m_last, m_win;
    int         m_a, m_b, m_left;
    logic       exp_done0, exp_done1, exp_busy;
    logic [7:0] exp_prod0, exp_prod1;
    logic [3:0] exp_mul_a, exp_mul_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model by one cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({done0, done1, busy, prod0, prod1, mul_a, mul_b} !==
                {exp_done0, exp_done1, exp_busy, exp_prod0, exp_prod1, exp_mul_a, exp_mul_b}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t: got done=%b%b busy=%b prod=%0d/%0d mul=%0d*%0d, expected done=%b%b busy=%b prod=%0d/%0d mul=%0d*%0d",
                         $time, done0, done1, busy, prod0, prod1, mul_a, mul_b,
                         exp_done0, exp_done1, exp_busy, exp_prod0, exp_prod1, exp_mul_a, exp_mul_b);
            end
        end
        exp_done0 = 1'b0;
        exp_done1 = 1'b0;
        if (rst) begin
            m_valid = 1'b1; m_active = 1'b0; m_last = 1'b1; m_win = 1'b0;
            exp_busy = 1'b0; exp_prod0 = 8'd0; exp_prod1 = 8'd0;
            exp_mul_a = 4'd0; exp_mul_b = 4'd0;
        end else if (!m_active) begin
            if (req0 || req1) begin
                m_win    = (req0 && req1) ? !m_last : req1;
                m_last   = m_win;
                m_a      = m_win ? int'(a1) : int'(a0);
                m_b      = m_win ? int'(b1) : int'(b0);
                m_left   = SC;
                m_active = 1'b1;
                exp_busy = 1'b1;
                exp_mul_a = 4'(m_a);
                exp_mul_b = 4'(m_b);
            end else begin
                exp_busy = 1'b0;
            end
        end else if (m_left == 0) begin
            m_active = 1'b0;
            exp_busy = 1'b0;
        end else begin
            m_left--;
            exp_busy = 1'b1;
            if (m_left == 0) begin
                if (m_win) begin
                    exp_done1 = 1'b1; exp_prod1 = 8'(m_a * m_b);
                end else begin
                    exp_done0 = 1'b1; exp_prod0 = 8'(m_a * m_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_prod", {prod0, prod1}, 0);
        chk("rst_mul", {mul_a, mul_b}, 0);
        rst = 1'b0;
    endtask

    int seq[$];

    // Requesters hold req until their done, drop for a cycle, then re-raise at random.
    task automatic drive(input int n, input int pct, input int rst_pm, input bit rec);
        for (int i = 0; i < n; i++) begin
            tick();
            if (rec && done0) seq.push_back(0);
            if (rec && done1) seq.push_back(1);
            a0 = 4'($urandom); b0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom);
            if (rst) begin
                rst = 1'b0;
            end else if (int'($urandom_range(999)) < rst_pm) begin
                rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (req0 && exp_done0) req0 = 1'b0;
                else if (!req0 && int'($urandom_range(99)) < pct) req0 = 1'b1;
                if (req1 && exp_done1) req1 = 1'b0;
                else if (!req1 && int'($urandom_range(99)) < pct) req1 = 1'b1;
            end
        end
    endtask

    initial begin
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        do_reset();

        // Single request 3*5
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        tick(); chk("s_mul_a_c1", mul_a, 3); chk("s_mul_b_c1", mul_b, 5); chk("s_busy_c1", busy, 1);
        tick(); chk("s_mul_a_c2", mul_a, 3); chk("s_done_c2", done0, 0);
        tick(); chk("s_done0_c3", done0, 1); chk("s_prod0", prod0, 15); chk("s_prod1", prod1, 0);
        req0 = 1'b0;
        tick(); chk("s_done0_c4", done0, 0); chk("s_busy_c4", busy, 0);

        // Tie: req0 wins first after reset, req1 four cycles later
        do_reset();
        req0 = 1'b1; req1 = 1'b1; a0 = 4'd11; b0 = 4'd15; a1 = 4'd7; b1 = 4'd9;
        tick(); tick(); tick();
        chk("t_done0", done0, 1); chk("t_prod0", prod0, 165); chk("t_done1_early", done1, 0);
        req0 = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t_done1", done1, 1); chk("t_prod1", prod1, 63); chk("t_prod0_hold", prod0, 165);
        req1 = 1'b0;
        tick();

        // Boundaries: 15*15 with operands changed during WAIT, then 0*15
        req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
        tick(); a0 = 4'd0; b0 = 4'd0;
        tick(); tick();
        chk("b_prod0_225", prod0, 225);
        req0 = 1'b0;
        tick();
        req1 = 1'b1; a1 = 4'd0; b1 = 4'd15;
        tick(); tick(); tick();
        chk("b_done1", done1, 1); chk("b_prod1_0", prod1, 0); chk("b_prod0_hold", prod0, 225);
        req1 = 1'b0;
        tick();

        // Reset in the second WAIT cycle aborts without a done pulse
        req0 = 1'b1; a0 = 4'd6; b0 = 4'd7;
        tick(); tick();
        rst = 1'b1; req0 = 1'b0;
        tick();
        chk("r_done", {done0, done1}, 0); chk("r_busy", busy, 0); chk("r_prod", {prod0, prod1}, 0);
        rst = 1'b0; req1 = 1'b1; a1 = 4'd2; b1 = 4'd2;
        tick(); tick(); tick();
        chk("r_done1", done1, 1); chk("r_prod1", prod1, 4);
        req1 = 1'b0;
        tick();

        // Fairness: both always re-raised, grants must alternate 0,1,0,1
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        seq.delete();
        drive(16, 100, 0, 1'b1);
        chk("f_count", seq.size(), 4);
        for (int i = 0; i < 4 && i < seq.size(); i++) chk("f_order", seq[i], i % 2);

        // Random traffic with occasional resets
        drive(4000, 60, 3, 1'b0);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
